// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: BRAM read port plus instruction stream handshake
interface instr_fetch_buffer_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) ();
   logic                  mem_r_valid;
   logic [ADDR_WIDTH-1:0] mem_r_addr;
   logic [DATA_WIDTH-1:0] mem_r_data;
   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instr_data;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_ready;
   modport master (
      output mem_r_valid, mem_r_addr, instr_valid, instr_data, instr_pc,
      input  mem_r_data, instr_ready
   );
   modport slave (
      input  mem_r_valid, mem_r_addr, instr_valid, instr_data, instr_pc,
      output mem_r_data, instr_ready
   );
endinterface

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential BRAM fetch into a credit-limited FIFO with redirect/stop flush
module instr_fetch_buffer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_pc,
   input  logic                  stop,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  busy,
   instr_fetch_buffer_if.master  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic                  pending;
   logic [ADDR_WIDTH-1:0] pending_pc;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc [DEPTH];
   logic                  run;
   logic                  flush;
   logic                  issue;
   logic                  push;
   logic                  pop;

   assign run   = state == RUN;
   assign flush = stop || redirect_valid;
   // credit counts the in-flight read so a returning word always has a free slot
   assign issue = run && !flush && (count + CW'(pending) < DEPTH_C);
   assign push  = run && pending && !flush;
   assign pop   = bus.instr_valid && bus.instr_ready;

   assign bus.mem_r_valid = issue;
   assign bus.mem_r_addr  = fetch_pc;
   assign bus.instr_valid = count != '0;
   assign bus.instr_data  = bus.instr_valid ? fifo_data[rd_ptr] : '0;
   assign bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr] : '0;

   // control FSM, fetch pointer, in-flight tracking and FIFO bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         fetch_pc   <= '0;
         pending    <= 1'b0;
         pending_pc <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else if (!run) begin
         if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            fetch_pc <= start_pc;
         end
      end else if (flush) begin
         pending <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            fetch_pc <= redirect_pc;
         end
      end else begin
         pending <= issue;
         if (issue) begin
            pending_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + ADDR_WIDTH'(1);
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are masked at the output so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= bus.mem_r_data;
         fifo_pc[wr_ptr]   <= pending_pc;
      end
   end
endmodule
